// File: rtl/mbist_pkg.sv
// Shared MBIST types: background FSM state and the (background index, polarity) step.
// The step index is sized generously; users slice it down to their own index width.
package mbist_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } bg_state_t;

  localparam int STEP_IDX_W = 8;

  typedef struct packed {
    logic [STEP_IDX_W-1:0] idx;
    logic                  inv;
  } bg_step_t;

  localparam bg_step_t STEP_FIRST = '{idx: '0, inv: 1'b0};

  // Step order: (k,0) -> (k,1) -> (k+1,0)
  function automatic bg_step_t step_advance(input bg_step_t s);
    bg_step_t r;
    r = s;
    if (s.inv) begin
      r.idx = s.idx + STEP_IDX_W'(1);
      r.inv = 1'b0;
    end else begin
      r.inv = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bg_pattern.sv
// Combinational data background: bg0 = all zeros, bgk bit j = NOT bit (k-1) of j.
module bg_pattern #(
  parameter int WLENGTH = 8
) (
  input  logic [((($clog2(WLENGTH) + 1) > 1) ? $clog2($clog2(WLENGTH) + 1) : 1)-1:0] idx,
  output logic [WLENGTH-1:0] word
);

  localparam int NUM_BG = $clog2(WLENGTH) + 1;
  localparam int IDX_W  = (NUM_BG > 1) ? $clog2(NUM_BG) : 1;

  always_comb begin
    word = '0;
    for (int k = 1; k < NUM_BG; k++) begin
      if (idx == IDX_W'(k)) begin
        for (int j = 0; j < WLENGTH; j++) begin
          word[j] = (((j >> (k - 1)) % 2) == 0);
        end
      end
    end
  end

endmodule

// File: rtl/data_bg_gen.sv
// MBIST data background generator: step FSM plus a two-stage pattern pipeline.
// Define DATA_BG_ROW_CB_EN to enable row-parity inversion (row checkerboard).
module data_bg_gen
  import mbist_pkg::*;
#(
  parameter int WLENGTH = 8,
  parameter int ADDR_W  = 8,
  parameter int ROW_LSB = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                next,
  input  logic                rcb_mode,
  input  logic                req_valid,
  input  logic [ADDR_W-1:0]   addr,
  output logic                out_valid,
  output logic [WLENGTH-1:0]  out_data,
  output logic [((($clog2(WLENGTH) + 1) > 1) ? $clog2($clog2(WLENGTH) + 1) : 1)-1:0] bg_idx,
  output logic                bg_inv,
  output logic                busy,
  output logic                done
);

  localparam int NUM_BG   = $clog2(WLENGTH) + 1;
  localparam int BG_IDX_W = (NUM_BG > 1) ? $clog2(NUM_BG) : 1;

  bg_state_t    state, state_n;
  bg_step_t     step, step_n;
  logic         done_n;
  logic         step_last;

  logic               s1_valid;
  logic [WLENGTH-1:0] s1_word;
  logic               s1_inv;
  logic [WLENGTH-1:0] bg_word;
  logic               inv_flag;
  logic               unused_ok;

  assign step_last = step.inv && (step.idx == STEP_IDX_W'(NUM_BG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      step  <= STEP_FIRST;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      step  <= step_n;
      done  <= done_n;
    end
  end

  // abort outranks next; start is only looked at in IDLE
  always_comb begin
    state_n = state;
    step_n  = step;
    done_n  = 1'b0;
    if (state == ST_RUN) begin
      if (abort) begin
        state_n = ST_IDLE;
        step_n  = STEP_FIRST;
      end else if (next) begin
        if (step_last) begin
          state_n = ST_IDLE;
          step_n  = STEP_FIRST;
          done_n  = 1'b1;
        end else begin
          step_n = step_advance(step);
        end
      end
    end else begin
      step_n = STEP_FIRST;
      if (start && !abort) state_n = ST_RUN;
    end
  end

  assign busy   = (state == ST_RUN);
  assign bg_idx = step.idx[BG_IDX_W-1:0];
  assign bg_inv = step.inv;

  bg_pattern #(.WLENGTH(WLENGTH)) u_bg_pattern (
    .idx  (bg_idx),
    .word (bg_word)
  );

`ifdef DATA_BG_ROW_CB_EN
  assign inv_flag = bg_inv ^ (rcb_mode & addr[ROW_LSB]);
`else
  assign inv_flag = bg_inv;
`endif

  assign unused_ok = ^{rcb_mode, addr, step.idx};

  // Stage 1 samples the pre-advance step, so a request alongside next/abort sees the old step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_word   <= '0;
      s1_inv    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      s1_valid  <= req_valid;
      s1_word   <= bg_word;
      s1_inv    <= inv_flag;
      out_valid <= s1_valid;
      if (s1_valid) out_data <= s1_inv ? ~s1_word : s1_word;
    end
  end

endmodule

// File: tb/tb_data_bg_gen.sv
// Directed bench for data_bg_gen (WLENGTH=8, ROW_LSB=4); DATA_BG_ROW_CB_EN selects row-CB expectations.
module tb_data_bg_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       next;
  logic       rcb_mode;
  logic       req_valid;
  logic [7:0] addr;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] bg_idx;
  logic       bg_inv;
  logic       busy;
  logic       done;

  int total;
  int bad;
  int done_cnt;
  int ov_cnt;

  data_bg_gen #(.WLENGTH(8), .ADDR_W(8), .ROW_LSB(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .next      (next),
    .rcb_mode  (rcb_mode),
    .req_valid (req_valid),
    .addr      (addr),
    .out_valid (out_valid),
    .out_data  (out_data),
    .bg_idx    (bg_idx),
    .bg_inv    (bg_inv),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (out_valid === 1'b1) ov_cnt++;
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_next(input int n);
    for (int i = 0; i < n; i++) begin
      next = 1'b1;
      @(negedge clk) next = 1'b0;
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    total++; if (bg_idx !== 2'd0) begin bad++; $display("FAIL reset_bg_idx got=%0d exp=0", bg_idx); end
    total++; if (bg_inv !== 1'b0) begin bad++; $display("FAIL reset_bg_inv got=%0b exp=0", bg_inv); end
  endtask

  task automatic test_idle();
    // next ignored in IDLE; request served with (bg0,0)
    @(negedge clk);
    next = 1'b1; req_valid = 1'b1; addr = 8'h00;
    @(negedge clk) next = 1'b0; req_valid = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_next_busy got=%0b exp=0", busy); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin
      bad++; $display("FAIL idle_req got=%0b/%h exp=1/00", out_valid, out_data);
    end
    // start and next together: start wins, step stays (0,0)
    start = 1'b1; next = 1'b1;
    @(negedge clk) start = 1'b0; next = 1'b0;
    total++; if (busy !== 1'b1 || bg_idx !== 2'd0 || bg_inv !== 1'b0) begin
      bad++; $display("FAIL start_next got=%0b/%0d/%0b exp=1/0/0", busy, bg_idx, bg_inv);
    end
    do_abort();
  endtask

  task automatic test_sequence();
    logic [7:0] exp_tab [8];
    int d0;
    exp_tab = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h33, 8'hCC, 8'h0F, 8'hF0};
    d0 = done_cnt;
    pulse_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL seq_busy got=%0b exp=1", busy); end
    for (int s = 0; s < 8; s++) begin
      req_valid = 1'b1; addr = 8'h00; next = 1'b1;
      @(negedge clk) req_valid = 1'b0; next = 1'b0;
      if (s == 7) begin
        total++; if (done !== 1'b1 || busy !== 1'b0) begin
          bad++; $display("FAIL seq_end got done=%0b busy=%0b exp=1/0", done, busy);
        end
      end
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_data !== exp_tab[s]) begin
        bad++; $display("FAIL seq_step%0d got=%0b/%h exp=1/%h", s, out_valid, out_data, exp_tab[s]);
      end
    end
    repeat (2) @(negedge clk);
    total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL seq_done_cnt got=%0d exp=%0d", done_cnt - d0, 1); end
  endtask

  task automatic test_row_cb();
    logic [7:0] exp_hi;
`ifdef DATA_BG_ROW_CB_EN
    exp_hi = 8'hAA;
`else
    exp_hi = 8'h55;
`endif
    pulse_start();
    pulse_next(2);
    rcb_mode = 1'b1; req_valid = 1'b1; addr = 8'h00;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rcb_latency got=%0b exp=0", out_valid); end
    addr = 8'h10;
    @(negedge clk) req_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 8'h55) begin
      bad++; $display("FAIL rcb_row0 got=%0b/%h exp=1/55", out_valid, out_data);
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_data !== exp_hi) begin
      bad++; $display("FAIL rcb_row1 got=%0b/%h exp=1/%h", out_valid, out_data, exp_hi);
    end
    rcb_mode = 1'b0; addr = 8'h00;
    do_abort();
  endtask

  task automatic test_abort();
    int d0;
    pulse_start();
    pulse_next(3);
    d0 = done_cnt;
    req_valid = 1'b1; addr = 8'h00;
    @(negedge clk) req_valid = 1'b0; abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    total++; if (busy !== 1'b0 || bg_idx !== 2'd0 || bg_inv !== 1'b0) begin
      bad++; $display("FAIL abort_state got=%0b/%0d/%0b exp=0/0/0", busy, bg_idx, bg_inv);
    end
    total++; if (out_valid !== 1'b1 || out_data !== 8'hAA) begin
      bad++; $display("FAIL abort_inflight got=%0b/%h exp=1/AA", out_valid, out_data);
    end
    repeat (3) @(negedge clk);
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt - d0); end
  endtask

  task automatic test_same_cycle();
    pulse_start();
    pulse_next(4);
    req_valid = 1'b1; next = 1'b1;
    @(negedge clk) next = 1'b0;
    @(negedge clk) req_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 8'h33) begin
      bad++; $display("FAIL same_cycle_pre got=%0b/%h exp=1/33", out_valid, out_data);
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_data !== 8'hCC) begin
      bad++; $display("FAIL same_cycle_post got=%0b/%h exp=1/CC", out_valid, out_data);
    end
    do_abort();
  endtask

  task automatic test_reset_mid();
    pulse_start();
    req_valid = 1'b1; next = 1'b1;
    @(posedge clk);
    #2;
    req_valid = 1'b0; next = 1'b0;
    rst_n = 1'b0;
    ov_cnt = 0;
    #1;
    total++; if (busy !== 1'b0 || bg_inv !== 1'b0 || bg_idx !== 2'd0 || done !== 1'b0) begin
      bad++; $display("FAIL rst_mid_state got=%0b/%0b/%0d/%0b exp=0/0/0/0", busy, bg_inv, bg_idx, done);
    end
    total++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      bad++; $display("FAIL rst_mid_out got=%0b/%h exp=0/00", out_valid, out_data);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (ov_cnt !== 0) begin bad++; $display("FAIL rst_mid_discard got=%0d exp=0", ov_cnt); end
  endtask

  initial begin
    total = 0; bad = 0; done_cnt = 0; ov_cnt = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; next = 1'b0;
    rcb_mode = 1'b0; req_valid = 1'b0; addr = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_idle();
    test_sequence();
    test_row_cb();
    test_abort();
    test_same_cycle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_bg_gen.md
DATA_BG_GEN -- requirements
Module: data_bg_gen

Interface
REQ-001 Parameter WLENGTH, default 8: data word width; power of two, at least 2.
REQ-002 Parameter ADDR_W, default 8: address width.
REQ-003 Parameter ROW_LSB, default 4: address bit giving row parity; below ADDR_W.
REQ-004 Derived NUM_BG = log2(WLENGTH)+1 and BG_IDX_W = max(1, clog2(NUM_BG)); SHALL NOT be overridable.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  begin a background sequence.
REQ-008 abort  in  1  synchronous sequence cancel.
REQ-009 next  in  1  advance one sequence step.
REQ-010 rcb_mode  in  1  1 = row checkerboard (row-parity inversion), 0 = plain checkerboard.
REQ-011 req_valid  in  1  pattern request this cycle.
REQ-012 addr  in  ADDR_W  request address.
REQ-013 out_valid  out  1  out_data valid.
REQ-014 out_data  out  WLENGTH  pattern word.
REQ-015 bg_idx  out  BG_IDX_W  current background index.
REQ-016 bg_inv  out  1  current polarity.
REQ-017 busy  out  1  sequence active.
REQ-018 done  out  1  one-cycle end-of-sequence pulse.

Function
REQ-019 Background k: bg0 is all zeros; for k≥1, bit j = NOT bit (k-1) of j (WLENGTH=8 gives 0x55, 0x33, 0x0F).
REQ-020 States are IDLE and RUN, with step order (bg0,0),(bg0,1),(bg1,0),(bg1,1)...(bg[NUM_BG-1],1).
REQ-021 IDLE: bg_idx=0, bg_inv=0.
REQ-022 IDLE and start: go to RUN at step (0,0).
REQ-023 RUN and next: advance one step; at the final step, done pulses next cycle and the FSM returns to IDLE.
REQ-024 Ignored inputs: next in IDLE, start in RUN.
REQ-025 start and next together in IDLE: start wins; the sequence stays at step (0,0).
REQ-026 abort has priority over start and next; RUN→IDLE, no done pulse.
REQ-027 busy=1 exactly while in RUN.
REQ-028 Datapath is a two-stage pipeline: stage 1 registers background word and inversion flag; stage 2 registers out_data.
REQ-029 out_valid follows req_valid with latency 2; a new request is accepted every cycle.
REQ-030 The inversion flag is bg_inv XOR (rcb_mode AND addr[ROW_LSB]), sampled at the request cycle.
REQ-031 A request in the same cycle as next or abort uses the pre-advance step.
REQ-032 Requests in IDLE are served with (bg0,0).
REQ-033 abort SHALL NOT flush in-flight requests.

Reset
REQ-034 rst_n low forces: FSM IDLE, bg_idx=0, bg_inv=0, busy=0, done=0, out_valid=0, out_data=0, all pipeline registers cleared; in-flight requests are discarded.
REQ-035 Reset SHALL act immediately, without a clock edge; release is synchronous to clk.

Configuration
REQ-036 Macro DATA_BG_ROW_CB_EN defined: row-parity inversion per REQ-030.
REQ-037 Macro DATA_BG_ROW_CB_EN undefined: rcb_mode and addr are ignored, the inversion flag equals bg_inv, and ports are unchanged.

Structure
REQ-038 Shared package mbist_pkg SHALL hold the FSM state enum and the background-index/polarity step typedef.
REQ-039 Sub-module bg_pattern: combinational background word from index, parameterised by WLENGTH.

Verification (WLENGTH=8, ROW_LSB=4)
REQ-040 Reset mid-RUN -> all outputs 0 immediately, and the pending request produces no out_valid.
REQ-041 start, then one req (addr=0) plus next per step, 8 steps -> out_data 00,FF,55,AA,33,CC,0F,F0; done pulses once; busy falls.
REQ-042 Macro on, rcb_mode=1, step (bg1,0): addr=0x00 -> 0x55 and addr=0x10 -> 0xAA, each 2 cycles after req.
REQ-043 Macro off, same stimulus as REQ-042 -> 0x55 for both addresses.
REQ-044 abort after 3 nexts with one request in flight -> busy=0, bg_idx=0, no done, and the in-flight request still returns 0xAA.
REQ-045 req and next in the same cycle at step (bg2,0) -> 0x33, and the following req -> 0xCC.
